sal_cmd_arb: RTL and testbench

Timing-aware DRAM command arbiter between the per-bank controllers and the DRAM command/address bus. Each cycle it selects at most one command from per-bank ACT/RD/WR/PRE/REF requests. Selection uses fixed class priority with round-robin fairness among banks inside each class. Inter-bank timing (tRRD, tFAW, tCCD, tWTR) is enforced so that only legal commands are granted; the chosen command is registered onto the command bus.

---
 rtl/sal_cmd_arb.sv | 189 ++++++++++++++++++
 tb/tb_sal_cmd_arb.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/sal_cmd_arb.sv
// rtl/sal_cmd_arb.sv - DRAM command arbiter with class priority, per-class round-robin and tRRD/tFAW/tCCD/tWTR gating
module sal_cmd_arb #(
    parameter int BK_CNT = 16,
    parameter int RA_W   = 16,
    parameter int CA_W   = 10,
    parameter int ID_W   = 4,
    parameter int LEN_W  = 4,
    parameter int T_RRD  = 4,
    parameter int T_FAW  = 20,
    parameter int T_CCD  = 4,
    parameter int T_WTR  = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [BK_CNT-1:0]          act_req,
    input  logic [BK_CNT-1:0]          rd_req,
    input  logic [BK_CNT-1:0]          wr_req,
    input  logic [BK_CNT-1:0]          pre_req,
    input  logic [BK_CNT-1:0]          ref_req,
    input  logic [BK_CNT*RA_W-1:0]     ra_flat,
    input  logic [BK_CNT*CA_W-1:0]     ca_flat,
    input  logic [BK_CNT*ID_W-1:0]     id_flat,
    input  logic [BK_CNT*LEN_W-1:0]    len_flat,
    output logic [BK_CNT-1:0]          act_gnt,
    output logic [BK_CNT-1:0]          rd_gnt,
    output logic [BK_CNT-1:0]          wr_gnt,
    output logic [BK_CNT-1:0]          pre_gnt,
    output logic [BK_CNT-1:0]          ref_gnt,
    output logic                       cmd_valid,
    output logic [2:0]                 cmd_type,
    output logic [$clog2(BK_CNT)-1:0]  cmd_ba,
    output logic [RA_W-1:0]            cmd_ra,
    output logic [CA_W-1:0]            cmd_ca,
    output logic [ID_W-1:0]            cmd_id,
    output logic [LEN_W-1:0]           cmd_len
);

    localparam int BA_W  = $clog2(BK_CNT);
    localparam int NCLS  = 5;
    localparam int FAW_W = T_FAW - 1;
    localparam int RRD_W = $clog2(T_RRD + 1);
    localparam int CCD_W = $clog2(T_CCD + 1);
    localparam int WTR_W = $clog2(T_WTR + 1);

    localparam logic [2:0] CLS_ACT = 3'd0;
    localparam logic [2:0] CLS_RD  = 3'd1;
    localparam logic [2:0] CLS_WR  = 3'd2;

    logic [NCLS-1:0][BK_CNT-1:0] req_all;
    logic [NCLS-1:0][BK_CNT-1:0] gnt_all;
    logic [NCLS-1:0]             cls_elig;
    logic [NCLS-1:0]             cls_found;
    logic [NCLS-1:0][BA_W-1:0]   cls_pick;
    logic [BA_W-1:0]             idx;
    logic                        win_valid;
    logic [2:0]                  win_cls;
    logic [BA_W-1:0]             win_bank;
    logic                        issue;
    logic                        faw_ok;

    logic [NCLS-1:0][BA_W-1:0]   ptr_q, ptr_d;
    logic [RRD_W-1:0]            rrd_q, rrd_d;
    logic [CCD_W-1:0]            ccd_q, ccd_d;
    logic [WTR_W-1:0]            wtr_q, wtr_d;
    logic [FAW_W-1:0]            faw_q, faw_d;
    logic                        cmd_valid_q, cmd_valid_d;
    logic [2:0]                  cmd_type_q, cmd_type_d;
    logic [BA_W-1:0]             cmd_ba_q, cmd_ba_d;
    logic [RA_W-1:0]             cmd_ra_q, cmd_ra_d;
    logic [CA_W-1:0]             cmd_ca_q, cmd_ca_d;
    logic [ID_W-1:0]             cmd_id_q, cmd_id_d;
    logic [LEN_W-1:0]            cmd_len_q, cmd_len_d;

    assign req_all = {ref_req, pre_req, wr_req, rd_req, act_req};
    assign faw_ok  = ($countones(faw_q) < 4);

    // Every class runs its own round-robin search; the priority pick then only
    // considers classes that both request and are timing-eligible.
    always_comb begin
        cls_elig  = {1'b1, 1'b1, (ccd_q == '0), (ccd_q == '0) && (wtr_q == '0),
                     (rrd_q == '0) && faw_ok};
        cls_found = '0;
        cls_pick  = '0;
        idx       = '0;
        win_valid = 1'b0;
        win_cls   = '0;
        win_bank  = '0;
        gnt_all   = '0;
        for (int c = 0; c < NCLS; c++) begin
            for (int i = 0; i < BK_CNT; i++) begin
                idx = ptr_q[c] + BA_W'(i);
                if (!cls_found[c] && req_all[c][idx]) begin
                    cls_found[c] = 1'b1;
                    cls_pick[c]  = idx;
                end
            end
        end
        for (int c = 0; c < NCLS; c++) begin
            if (!win_valid && cls_found[c] && cls_elig[c]) begin
                win_valid = 1'b1;
                win_cls   = 3'(c);
                win_bank  = cls_pick[c];
            end
        end
        if (win_valid && !rst) begin
            gnt_all[win_cls][win_bank] = 1'b1;
        end
    end

    assign issue   = win_valid && !rst;
    assign act_gnt = gnt_all[0];
    assign rd_gnt  = gnt_all[1];
    assign wr_gnt  = gnt_all[2];
    assign pre_gnt = gnt_all[3];
    assign ref_gnt = gnt_all[4];

    always_comb begin
        ptr_d       = ptr_q;
        rrd_d       = (rrd_q != '0) ? rrd_q - 1'b1 : rrd_q;
        ccd_d       = (ccd_q != '0) ? ccd_q - 1'b1 : ccd_q;
        wtr_d       = (wtr_q != '0) ? wtr_q - 1'b1 : wtr_q;
        faw_d       = {faw_q[FAW_W-2:0], issue && (win_cls == CLS_ACT)};
        cmd_valid_d = 1'b0;
        cmd_type_d  = '0;
        cmd_ba_d    = '0;
        cmd_ra_d    = '0;
        cmd_ca_d    = '0;
        cmd_id_d    = '0;
        cmd_len_d   = '0;
        if (issue) begin
            ptr_d[win_cls] = win_bank + 1'b1;
            cmd_valid_d    = 1'b1;
            cmd_type_d     = win_cls + 3'd1;
            cmd_ba_d       = win_bank;
            if (win_cls == CLS_ACT) begin
                rrd_d    = RRD_W'(T_RRD - 1);
                cmd_ra_d = ra_flat[win_bank*RA_W +: RA_W];
            end
            if (win_cls == CLS_RD || win_cls == CLS_WR) begin
                ccd_d     = CCD_W'(T_CCD - 1);
                cmd_ca_d  = ca_flat[win_bank*CA_W +: CA_W];
                cmd_id_d  = id_flat[win_bank*ID_W +: ID_W];
                cmd_len_d = len_flat[win_bank*LEN_W +: LEN_W];
            end
            if (win_cls == CLS_WR) begin
                wtr_d = WTR_W'(T_WTR - 1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q       <= '0;
            rrd_q       <= '0;
            ccd_q       <= '0;
            wtr_q       <= '0;
            faw_q       <= '0;
            cmd_valid_q <= 1'b0;
            cmd_type_q  <= '0;
            cmd_ba_q    <= '0;
            cmd_ra_q    <= '0;
            cmd_ca_q    <= '0;
            cmd_id_q    <= '0;
            cmd_len_q   <= '0;
        end else begin
            ptr_q       <= ptr_d;
            rrd_q       <= rrd_d;
            ccd_q       <= ccd_d;
            wtr_q       <= wtr_d;
            faw_q       <= faw_d;
            cmd_valid_q <= cmd_valid_d;
            cmd_type_q  <= cmd_type_d;
            cmd_ba_q    <= cmd_ba_d;
            cmd_ra_q    <= cmd_ra_d;
            cmd_ca_q    <= cmd_ca_d;
            cmd_id_q    <= cmd_id_d;
            cmd_len_q   <= cmd_len_d;
        end
    end

    assign cmd_valid = cmd_valid_q;
    assign cmd_type  = cmd_type_q;
    assign cmd_ba    = cmd_ba_q;
    assign cmd_ra    = cmd_ra_q;
    assign cmd_ca    = cmd_ca_q;
    assign cmd_id    = cmd_id_q;
    assign cmd_len   = cmd_len_q;

endmodule

// File: tb/tb_sal_cmd_arb.sv
// tb/tb_sal_cmd_arb.sv - directed table-driven bench for sal_cmd_arb
module tb_sal_cmd_arb;

    localparam int NONE = 7;

    logic        clk;
    logic        rst;
    logic [15:0] act_req, rd_req, wr_req, pre_req, ref_req;
    logic [255:0] ra_flat;
    logic [159:0] ca_flat;
    logic [63:0]  id_flat;
    logic [63:0]  len_flat;
    logic [15:0] act_gnt, rd_gnt, wr_gnt, pre_gnt, ref_gnt;
    logic        cmd_valid;
    logic [2:0]  cmd_type;
    logic [3:0]  cmd_ba;
    logic [15:0] cmd_ra;
    logic [9:0]  cmd_ca;
    logic [3:0]  cmd_id;
    logic [3:0]  cmd_len;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic        rst;
        logic [15:0] act;
        logic [15:0] rd;
        logic [15:0] wr;
        logic [15:0] pr;
        logic [15:0] rf;
        int          exp_cls;
        int          exp_bank;
    } vec_t;

    vec_t vecs[$];

    sal_cmd_arb dut (
        .clk      (clk),
        .rst      (rst),
        .act_req  (act_req),
        .rd_req   (rd_req),
        .wr_req   (wr_req),
        .pre_req  (pre_req),
        .ref_req  (ref_req),
        .ra_flat  (ra_flat),
        .ca_flat  (ca_flat),
        .id_flat  (id_flat),
        .len_flat (len_flat),
        .act_gnt  (act_gnt),
        .rd_gnt   (rd_gnt),
        .wr_gnt   (wr_gnt),
        .pre_gnt  (pre_gnt),
        .ref_gnt  (ref_gnt),
        .cmd_valid(cmd_valid),
        .cmd_type (cmd_type),
        .cmd_ba   (cmd_ba),
        .cmd_ra   (cmd_ra),
        .cmd_ca   (cmd_ca),
        .cmd_id   (cmd_id),
        .cmd_len  (cmd_len)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] f_ra(input int b);
        return 16'hA000 | 16'(b);
    endfunction
    function automatic logic [9:0] f_ca(input int b);
        return 10'h200 | 10'(b);
    endfunction
    function automatic logic [3:0] f_id(input int b);
        return 4'(15 - b);
    endfunction
    function automatic logic [3:0] f_len(input int b);
        return 4'(b + 3);
    endfunction

    task automatic add(input logic r, input logic [15:0] a, input logic [15:0] rdv,
                       input logic [15:0] wrv, input logic [15:0] prv, input logic [15:0] rfv,
                       input int cls, input int bank);
        vec_t v;
        v.rst = r; v.act = a; v.rd = rdv; v.wr = wrv; v.pr = prv; v.rf = rfv;
        v.exp_cls = cls; v.exp_bank = bank;
        vecs.push_back(v);
    endtask

    task automatic run_vec(input string name, input int n, input vec_t v);
        logic [4:0][15:0] exp_g;
        logic [4:0][15:0] got_g;
        logic [41:0]      exp_c;
        logic [41:0]      got_c;
        logic [2:0]       ty;
        @(negedge clk);
        rst = v.rst; act_req = v.act; rd_req = v.rd; wr_req = v.wr;
        pre_req = v.pr; ref_req = v.rf;
        #1;
        exp_g = '0;
        if (v.exp_cls < 5) exp_g[v.exp_cls][v.exp_bank] = 1'b1;
        got_g = {ref_gnt, pre_gnt, wr_gnt, rd_gnt, act_gnt};
        n_checks++;
        if (got_g !== exp_g) begin
            n_errors++;
            $display("FAIL %s[%0d] gnt got %h exp %h", name, n, got_g, exp_g);
        end
        @(posedge clk);
        #1;
        exp_c = '0;
        if (!v.rst && v.exp_cls < 5) begin
            ty = 3'(v.exp_cls + 1);
            exp_c[41]    = 1'b1;
            exp_c[40:38] = ty;
            exp_c[37:34] = 4'(v.exp_bank);
            if (v.exp_cls == 0) exp_c[33:18] = f_ra(v.exp_bank);
            if (v.exp_cls == 1 || v.exp_cls == 2) begin
                exp_c[17:8] = f_ca(v.exp_bank);
                exp_c[7:4]  = f_id(v.exp_bank);
                exp_c[3:0]  = f_len(v.exp_bank);
            end
        end
        got_c = {cmd_valid, cmd_type, cmd_ba, cmd_ra, cmd_ca, cmd_id, cmd_len};
        n_checks++;
        if (got_c !== exp_c) begin
            n_errors++;
            $display("FAIL %s[%0d] cmd got %h exp %h", name, n, got_c, exp_c);
        end
    endtask

    initial begin
        vec_t v;
        rst = 1'b1;
        act_req = '0; rd_req = '0; wr_req = '0; pre_req = '0; ref_req = '0;
        for (int b = 0; b < 16; b++) begin
            ra_flat[b*16 +: 16] = f_ra(b);
            ca_flat[b*10 +: 10] = f_ca(b);
            id_flat[b*4 +: 4]   = f_id(b);
            len_flat[b*4 +: 4]  = f_len(b);
        end

        // reset with every request asserted
        for (int k = 0; k < 3; k++) add(1, '1, '1, '1, '1, '1, NONE, 0);
        // round-robin plus tCCD on RD
        for (int k = 0; k < 10; k++)
            add(0, 0, 16'h0005, 0, 0, 0,
                (k == 0 || k == 4 || k == 8) ? 1 : NONE, (k == 4) ? 2 : 0);
        add(1, 0, 0, 0, 0, 0, NONE, 0);
        // work conservation: PRE slips in while ACT waits for tRRD
        add(0, 16'h0001, 0, 0, 16'h0008, 0, 0, 0);
        add(0, 0,        0, 0, 16'h0008, 0, 3, 3);
        add(0, 16'h0001, 0, 0, 0, 0, NONE, 0);
        add(0, 16'h0001, 0, 0, 0, 0, NONE, 0);
        add(0, 16'h0001, 0, 0, 0, 0, 0, 0);
        add(1, 0, 0, 0, 0, 0, NONE, 0);
        // tWTR: WR to bank 1 then RD to bank 2 waits 8 cycles
        add(0, 0, 0, 16'h0002, 0, 0, 2, 1);
        for (int k = 1; k < 9; k++) add(0, 0, 16'h0004, 0, 0, 0, (k == 8) ? 1 : NONE, 2);
        add(1, 0, 0, 0, 0, 0, NONE, 0);
        // tRRD/tFAW: fifth ACT waits until the first leaves the window
        for (int k = 0; k < 22; k++)
            add(0, '1, 0, 0, 0, 0,
                (k == 0 || k == 4 || k == 8 || k == 12 || k == 20) ? 0 : NONE,
                (k == 20) ? 4 : k / 4);
        add(1, 0, 0, 0, 0, 0, NONE, 0);
        // class priority with an ineligible WR not blocking PRE/REF
        add(0, 16'h0010, 16'h0020, 16'h0040, 16'h0080, 16'h0100, 0, 4);
        add(0, 0,        16'h0020, 16'h0040, 16'h0080, 16'h0100, 1, 5);
        add(0, 0,        0,        16'h0040, 16'h0080, 16'h0100, 3, 7);
        add(0, 0,        0,        16'h0040, 0,        16'h0100, 4, 8);
        add(0, 0,        0,        16'h0040, 0,        0,        NONE, 0);
        add(0, 0,        0,        16'h0040, 0,        0,        2, 6);
        add(1, 0, 0, 0, 0, 0, NONE, 0);
        // PRE pointer walks all banks and wraps
        for (int k = 0; k < 17; k++) add(0, 0, 0, 0, '1, 0, 3, k % 16);
        add(1, 0, 0, 0, 0, 0, NONE, 0);
        // sole requester granted every cycle
        for (int k = 0; k < 3; k++) add(0, 0, 0, 0, 0, 16'h8000, 4, 15);

        foreach (vecs[i]) run_vec("vec", i, vecs[i]);

        // reset in the middle of an ACT stream discards timing history
        v.act = '1; v.rd = '0; v.wr = '0; v.pr = '0; v.rf = '0;
        v.rst = 1'b1; v.exp_cls = NONE; v.exp_bank = 0;
        run_vec("midrst", 0, v);
        for (int k = 0; k < 10; k++) begin
            v.rst      = (k == 6 || k == 7);
            v.exp_cls  = (k == 0 || k == 4 || k == 8) ? 0 : NONE;
            v.exp_bank = (k == 4) ? 1 : 0;
            run_vec("midrst", k + 1, v);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
